// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM local-port arbiter: FSM states, read-tag layout, port helpers.
// Tag fields are sized for the largest supported configuration (8 ports, 8-bit size) so one struct fits every instance.
package sdram_arb_pkg;

  localparam int MAX_PORTS  = 8;
  localparam int PORT_ID_W  = $clog2(MAX_PORTS);
  localparam int TAG_SIZE_W = 8;

  typedef enum logic [0:0] {
    IDLE,
    WR_BURST
  } arb_state_t;

  typedef struct packed {
    logic [PORT_ID_W-1:0]  port_id;
    logic [TAG_SIZE_W-1:0] size;
  } rd_tag_t;

  function automatic logic [PORT_ID_W-1:0] next_port(input logic [PORT_ID_W-1:0] p,
                                                     input int                   num_ports);
    return (int'(p) == num_ports - 1) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/sdram_rd_tag_fifo.sv
// Synchronous FIFO for outstanding read tags; head visible combinationally, push/pop registered.
// Push is taken when not full or when a pop frees a slot in the same cycle; pop on empty is ignored.
module sdram_rd_tag_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/sdram_local_port_arbiter.sv
// Round-robin merge of NUM_PORTS local request ports onto one controller port, atomic write bursts, tagged read return.
// Command path is combinational (0 cycles), read return is 1 registered cycle; p_waitrequest stays high unless the beat is accepted.
module sdram_local_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS          = 4,
  parameter int ADDR_W             = 26,
  parameter int DATA_W             = 32,
  parameter int BE_W               = DATA_W / 8,
  parameter int SIZE_W             = 3,
  parameter int MAX_RD_OUTSTANDING = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS*ADDR_W-1:0] p_address,
  input  logic [NUM_PORTS*SIZE_W-1:0] p_size,
  input  logic [NUM_PORTS*BE_W-1:0]   p_be,
  input  logic [NUM_PORTS*DATA_W-1:0] p_wdata,
  input  logic [NUM_PORTS-1:0]        p_read_req,
  input  logic [NUM_PORTS-1:0]        p_write_req,
  output logic [NUM_PORTS-1:0]        p_waitrequest,
  output logic [DATA_W-1:0]           p_rdata,
  output logic [NUM_PORTS-1:0]        p_rdata_valid,
  output logic [ADDR_W-1:0]           local_address,
  output logic [SIZE_W-1:0]           local_size,
  output logic [BE_W-1:0]             local_be,
  output logic [DATA_W-1:0]           local_wdata,
  output logic                        local_read_req,
  output logic                        local_write_req,
  output logic                        local_burstbegin,
  input  logic                        local_ready,
  input  logic [DATA_W-1:0]           local_rdata,
  input  logic                        local_rdata_valid,
  input  logic                        local_init_done,
  output logic                        rd_fifo_full,
  output logic                        rd_unexpected
);

  arb_state_t            state;
  logic [PORT_ID_W-1:0]  rr_ptr, lock_port, grant, idx;
  logic [SIZE_W-1:0]     beats_left, eff_size;
  logic                  grant_vld, grant_wr, grant_rd, accept;
  logic [MAX_PORTS-1:0]  eligible, wait_pad, rdv_onehot;

  // Per-port views padded to MAX_PORTS so a PORT_ID_W-bit index is always in range.
  logic [ADDR_W-1:0]     addr_a [MAX_PORTS];
  logic [SIZE_W-1:0]     size_a [MAX_PORTS];
  logic [BE_W-1:0]       be_a   [MAX_PORTS];
  logic [DATA_W-1:0]     wdat_a [MAX_PORTS];
  logic [MAX_PORTS-1:0]  wr_a, rd_a;

  logic                  tag_full, tag_empty, tag_push, tag_pop;
  rd_tag_t               tag_in, tag_head;
  logic [TAG_SIZE_W-1:0] rd_cnt, rd_cnt_nxt;

  always_comb begin
    wr_a = '0;
    rd_a = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      addr_a[i] = '0;
      size_a[i] = '0;
      be_a[i]   = '0;
      wdat_a[i] = '0;
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      addr_a[i] = p_address[i*ADDR_W +: ADDR_W];
      size_a[i] = p_size[i*SIZE_W +: SIZE_W];
      be_a[i]   = p_be[i*BE_W +: BE_W];
      wdat_a[i] = p_wdata[i*DATA_W +: DATA_W];
      wr_a[i]   = p_write_req[i];
      rd_a[i]   = p_read_req[i];
    end
  end

  // Eligibility uses the registered full flag, so a pop in this cycle cannot admit a read now.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < MAX_PORTS; i++)
      eligible[i] = local_init_done & (wr_a[i] | (rd_a[i] & ~tag_full));
  end

  always_comb begin
    grant     = lock_port;
    grant_vld = 1'b0;
    idx       = '0;
    if (state == IDLE) begin
      grant = rr_ptr;
      for (int k = 0; k < NUM_PORTS; k++) begin
        idx = PORT_ID_W'((int'(rr_ptr) + k) % NUM_PORTS);
        if (!grant_vld && eligible[idx]) begin
          grant     = idx;
          grant_vld = 1'b1;
        end
      end
    end else begin
      grant_vld = local_init_done & wr_a[lock_port];
    end
    grant_vld = grant_vld & ~reset;
  end

  assign grant_wr = grant_vld & wr_a[grant];
  assign grant_rd = grant_vld & ~wr_a[grant];
  assign accept   = grant_vld & local_ready;
  assign eff_size = (size_a[grant] == '0) ? SIZE_W'(1) : size_a[grant];

  assign local_address    = addr_a[grant];
  assign local_size       = size_a[grant];
  assign local_be         = be_a[grant];
  assign local_wdata      = wdat_a[grant];
  assign local_write_req  = grant_wr;
  assign local_read_req   = grant_rd;
  assign local_burstbegin = grant_vld & (state == IDLE);

  always_comb begin
    wait_pad        = '1;
    wait_pad[grant] = ~accept;
  end
  assign p_waitrequest = wait_pad[NUM_PORTS-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      lock_port  <= '0;
      beats_left <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (grant_wr && eff_size != SIZE_W'(1)) begin
              beats_left <= eff_size - 1'b1;
              lock_port  <= grant;
              state      <= WR_BURST;
            end else begin
              rr_ptr <= next_port(grant, NUM_PORTS);
            end
          end
        end
        WR_BURST: begin
          if (accept) begin
            beats_left <= beats_left - 1'b1;
            if (beats_left == SIZE_W'(1)) begin
              rr_ptr <= next_port(lock_port, NUM_PORTS);
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tag_push = accept & grant_rd;
  assign tag_in   = '{port_id: grant, size: TAG_SIZE_W'(eff_size)};

  sdram_rd_tag_fifo #(
    .W     ($bits(rd_tag_t)),
    .DEPTH (MAX_RD_OUTSTANDING)
  ) u_rd_tag_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (tag_push),
    .push_dat (tag_in),
    .pop      (tag_pop),
    .pop_dat  (tag_head),
    .full     (tag_full),
    .empty    (tag_empty)
  );

  assign rd_fifo_full = tag_full;
  assign rd_cnt_nxt   = rd_cnt + 1'b1;
  assign tag_pop      = local_rdata_valid & ~tag_empty & (rd_cnt_nxt == tag_head.size);

  always_comb begin
    rdv_onehot                   = '0;
    rdv_onehot[tag_head.port_id] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_rdata       <= '0;
      p_rdata_valid <= '0;
      rd_cnt        <= '0;
      rd_unexpected <= 1'b0;
    end else begin
      p_rdata_valid <= '0;
      if (local_rdata_valid) begin
        if (tag_empty) begin
          rd_unexpected <= 1'b1;
        end else begin
          p_rdata_valid <= rdv_onehot[NUM_PORTS-1:0];
          p_rdata       <= local_rdata;
          rd_cnt        <= tag_pop ? '0 : rd_cnt_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_local_port_arbiter.sv
// Directed bench for sdram_local_port_arbiter: grant order, write bursts, tagged read return, full stall, error and reset.
module tb_sdram_local_port_arbiter;

  localparam int NP = 4;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [AW-1:0] addr [NP];
  logic [SW-1:0] sz   [NP];
  logic [BW-1:0] be   [NP];
  logic [DW-1:0] wd   [NP];
  logic [NP-1:0] rreq, wreq;

  logic [NP*AW-1:0] p_address;
  logic [NP*SW-1:0] p_size;
  logic [NP*BW-1:0] p_be;
  logic [NP*DW-1:0] p_wdata;
  logic [NP-1:0]    p_waitrequest, p_rdata_valid;
  logic [DW-1:0]    p_rdata, local_wdata, local_rdata;
  logic [AW-1:0]    local_address;
  logic [SW-1:0]    local_size;
  logic [BW-1:0]    local_be;
  logic             local_read_req, local_write_req, local_burstbegin;
  logic             local_ready, local_rdata_valid, local_init_done;
  logic             rd_fifo_full, rd_unexpected;

  for (genvar g = 0; g < NP; g++) begin : g_pack
    assign p_address[g*AW +: AW] = addr[g];
    assign p_size[g*SW +: SW]    = sz[g];
    assign p_be[g*BW +: BW]      = be[g];
    assign p_wdata[g*DW +: DW]   = wd[g];
  end

  sdram_local_port_arbiter #(
    .NUM_PORTS (NP), .ADDR_W (AW), .DATA_W (DW), .BE_W (BW), .SIZE_W (SW), .MAX_RD_OUTSTANDING (8)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .p_address         (p_address),
    .p_size            (p_size),
    .p_be              (p_be),
    .p_wdata           (p_wdata),
    .p_read_req        (rreq),
    .p_write_req       (wreq),
    .p_waitrequest     (p_waitrequest),
    .p_rdata           (p_rdata),
    .p_rdata_valid     (p_rdata_valid),
    .local_address     (local_address),
    .local_size        (local_size),
    .local_be          (local_be),
    .local_wdata       (local_wdata),
    .local_read_req    (local_read_req),
    .local_write_req   (local_write_req),
    .local_burstbegin  (local_burstbegin),
    .local_ready       (local_ready),
    .local_rdata       (local_rdata),
    .local_rdata_valid (local_rdata_valid),
    .local_init_done   (local_init_done),
    .rd_fifo_full      (rd_fifo_full),
    .rd_unexpected     (rd_unexpected)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  int          order [5] = '{0, 1, 2, 3, 0};
  logic [3:0]  w;

  initial begin
    reset = 1'b1; local_init_done = 1'b0; rreq = '0; wreq = '0;
    local_ready = 1'b0; local_rdata_valid = 1'b0; local_rdata = '0;
    for (int i = 0; i < NP; i++) begin
      addr[i] = AW'(32'h100 * (i + 1));
      sz[i]   = 3'd1;
      be[i]   = 4'hF;
      wd[i]   = 32'hD0D0_0000 + i;
    end
    #3;
    chk("rst_wr_req", local_write_req, 0);
    chk("rst_rd_req", local_read_req, 0);
    chk("rst_wait", p_waitrequest, 4'hF);
    chk("rst_rdv", p_rdata_valid, 0);
    chk("rst_unexp", rd_unexpected, 0);
    chk("rst_full", rd_fifo_full, 0);
    tick(); tick();
    reset = 1'b0;

    // No grants until the controller reports init done
    wreq = 4'hF; local_ready = 1'b1;
    settle();
    chk("noinit_wr_req", local_write_req, 0);
    chk("noinit_wait", p_waitrequest, 4'hF);
    tick();
    local_init_done = 1'b1;
    settle();
    chk("init_bb", local_burstbegin, 1);
    for (int n = 0; n < 5; n++) begin
      if (n > 0) settle();
      w = 4'hF; w[order[n]] = 1'b0;
      chk("rr_wait", p_waitrequest, w);
      chk("rr_addr", local_address, 32'h100 * (order[n] + 1));
      chk("rr_wr_req", local_write_req, 1);
      tick();
    end
    wreq = '0;

    // Port 1 four-beat burst with a ready gap, port 2 waiting
    sz[1] = 3'd4; wreq = 4'b0110; local_ready = 1'b1;
    settle();
    chk("bu_bb0", local_burstbegin, 1);
    chk("bu_wait0", p_waitrequest, 4'b1101);
    chk("bu_addr0", local_address, 26'h200);
    tick();
    local_ready = 1'b0;
    settle();
    chk("bu_gap_wr", local_write_req, 1);
    chk("bu_gap_bb", local_burstbegin, 0);
    chk("bu_gap_wait", p_waitrequest, 4'hF);
    chk("bu_gap_addr", local_address, 26'h200);
    tick();
    local_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      settle();
      chk("bu_wait", p_waitrequest, 4'b1101);
      chk("bu_bb", local_burstbegin, 0);
      tick();
    end
    wreq[1] = 1'b0;
    settle();
    chk("bu_p2_wait", p_waitrequest, 4'b1011);
    chk("bu_p2_bb", local_burstbegin, 1);
    chk("bu_p2_addr", local_address, 26'h300);
    tick();
    wreq = '0; sz[1] = 3'd1;

    // Port 3 reads 2 beats, then port 0 reads 1 beat
    sz[3] = 3'd2; rreq = 4'b1001;
    settle();
    chk("rd3_req", local_read_req, 1);
    chk("rd3_wr", local_write_req, 0);
    chk("rd3_size", local_size, 2);
    chk("rd3_wait", p_waitrequest, 4'b0111);
    tick();
    rreq[3] = 1'b0;
    settle();
    chk("rd0_wait", p_waitrequest, 4'b1110);
    chk("rd0_size", local_size, 1);
    tick();
    rreq = '0;
    local_rdata_valid = 1'b1; local_rdata = 32'hA1;
    settle();
    chk("ret_rdv0", p_rdata_valid, 0);
    tick();
    local_rdata = 32'hA2;
    settle();
    chk("ret_rdv1", p_rdata_valid, 4'b1000);
    chk("ret_dat1", p_rdata, 32'hA1);
    tick();
    local_rdata = 32'hA3;
    settle();
    chk("ret_rdv2", p_rdata_valid, 4'b1000);
    chk("ret_dat2", p_rdata, 32'hA2);
    tick();
    local_rdata_valid = 1'b0;
    settle();
    chk("ret_rdv3", p_rdata_valid, 4'b0001);
    chk("ret_dat3", p_rdata, 32'hA3);
    tick();
    settle();
    chk("ret_rdv4", p_rdata_valid, 0);
    tick();

    // Fill the tag FIFO with 8 single-beat reads from port 0
    sz[3] = 3'd1; rreq = 4'b0001;
    for (int n = 0; n < 8; n++) begin
      settle();
      chk("fill_wait", p_waitrequest, 4'b1110);
      if (n == 7) chk("fill_full_pre", rd_fifo_full, 0);
      tick();
    end
    wreq = 4'b0100;
    settle();
    chk("full_flag", rd_fifo_full, 1);
    chk("full_rd_req", local_read_req, 0);
    chk("full_wr_req", local_write_req, 1);
    chk("full_wait", p_waitrequest, 4'b1011);
    tick();
    wreq = '0;
    settle();
    chk("stall_rd_req", local_read_req, 0);
    chk("stall_wait", p_waitrequest, 4'hF);
    tick();
    local_rdata_valid = 1'b1; local_rdata = 32'hB1;
    settle();
    chk("pop_full_still", rd_fifo_full, 1);
    chk("pop_rd_req", local_read_req, 0);
    tick();
    local_rdata_valid = 1'b0;
    settle();
    chk("unstall_full", rd_fifo_full, 0);
    chk("unstall_rd_req", local_read_req, 1);
    chk("unstall_wait", p_waitrequest, 4'b1110);
    chk("unstall_rdv", p_rdata_valid, 4'b0001);
    chk("unstall_dat", p_rdata, 32'hB1);
    tick();
    rreq = '0;

    // Drain 8 tags, then one beat with nothing outstanding
    local_rdata_valid = 1'b1;
    repeat (8) tick();
    settle();
    chk("unexp_pre", rd_unexpected, 0);
    tick();
    local_rdata_valid = 1'b0;
    settle();
    chk("unexp_set", rd_unexpected, 1);
    chk("unexp_rdv", p_rdata_valid, 0);
    tick(); tick();
    settle();
    chk("unexp_sticky", rd_unexpected, 1);
    tick();

    // Reset in the middle of a 3-beat write burst
    sz[1] = 3'd3; wreq = 4'b0010;
    settle();
    chk("mid_bb0", local_burstbegin, 1);
    tick();
    settle();
    chk("mid_wr", local_write_req, 1);
    chk("mid_bb1", local_burstbegin, 0);
    #1 reset = 1'b1;
    #1;
    chk("arst_wr", local_write_req, 0);
    chk("arst_rd", local_read_req, 0);
    chk("arst_wait", p_waitrequest, 4'hF);
    chk("arst_unexp", rd_unexpected, 0);
    chk("arst_rdv", p_rdata_valid, 0);
    chk("arst_full", rd_fifo_full, 0);
    tick(); tick();
    reset = 1'b0;
    settle();
    chk("post_bb", local_burstbegin, 1);
    chk("post_wait", p_waitrequest, 4'b1101);
    tick();
    wreq = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
